// File: rtl/timer_counter_if.sv
// rtl/timer_counter_if.sv - bridge bus bundle between data-memory stage and the timer
//
// Purpose: groups the word-select, write strobe, write data, read data and
// interrupt line of one timer window.
// Signals:
//   Addr  word select (bus address bits [3:2])
//   WE    write strobe, one cycle per store
//   Din   write data
//   Dout  read data, combinational from Addr
//   IRQ   interrupt request toward CP0
// Modports: master = bus bridge side, slave = timer side.

interface timer_counter_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (
    output Addr,
    output WE,
    output Din,
    input  Dout,
    input  IRQ
  );

  modport slave (
    input  Addr,
    input  WE,
    input  Din,
    output Dout,
    output IRQ
  );
endinterface

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped down-counting timer with interrupt
//
// Purpose: down-counter reloaded from PRESET, one-shot or auto-reload, raising
// an interrupt flag when the count expires.
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-high reset
//   bus    timer_counter_if.slave (Addr, WE, Din in; Dout, IRQ out)
// Register map (Addr): 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (RO),
// 3 reserved (reads 0, writes dropped).

module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_flag;

  logic ctrl_wr;
  logic preset_wr;

  assign ctrl_wr   = bus.WE && (bus.Addr == 2'd0);
  assign preset_wr = bus.WE && (bus.Addr == 2'd1);

  // Host writes are applied first; the FSM assignments that follow override
  // them where the FSM must win (irq_flag set beats a clearing write). The
  // one case where the host must win (EN clear in INT) is guarded explicitly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ctrl     <= 4'd0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= bus.Din[3:0];
      end
      if (preset_wr) begin
        preset <= bus.Din[CNT_W-1:0];
      end
      if (ctrl_wr || preset_wr) begin
        irq_flag <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (ctrl[0]) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // EN dropped while heading into LOAD (e.g. from INT): give up the reload.
          if (ctrl[0]) begin
            count <= preset;
            state <= S_CNT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_CNT: begin
          if (!ctrl[0]) begin
            state <= S_IDLE;
          end else if (count > ONE) begin
            count <= count - ONE;
          end else begin
            // Covers both 1->0 and a zero preset; never decrements below 0.
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= S_INT;
          end
        end
        S_INT: begin
          if (ctrl[2:1] == 2'b01) begin
            irq_flag <= 1'b0;
            state    <= S_LOAD;
          end else begin
            if (!ctrl_wr) begin
              ctrl[0] <= 1'b0;
            end
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (bus.Addr)
      2'd0:    bus.Dout = {28'd0, ctrl};
      2'd1:    bus.Dout = 32'(preset);
      2'd2:    bus.Dout = 32'(count);
      default: bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = irq_flag & ctrl[3];

endmodule
